// File: rtl/avalon_pattern_gen.sv
// Test-pattern source that streams RGB pixels into an Avalon-MM streaming write port.
// Supports horizontal/vertical bars, checkerboard and solid colour.
module avalon_pattern_gen #(
  parameter int unsigned N_BARS  = 8,
  parameter int unsigned COORD_W = 11,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned WR_ADDR = 0
) (
  input  logic                clk_mm,
  input  logic                reset,
  input  logic                enable,
  input  logic [1:0]          mode,
  input  logic [23:0]         solid_rgb,
  input  logic [COORD_W-1:0]  x,
  input  logic [COORD_W-1:0]  y,
  input  logic [COORD_W-1:0]  horz,
  input  logic [COORD_W-1:0]  vert,
  output logic                write,
  output logic [ADDR_W-1:0]   address,
  output logic [DATA_W-1:0]   writedata,
  output logic [DATA_W/8-1:0] byteenable,
  input  logic                waitrequest,
  output logic                busy,
  output logic                frame_done
);

  localparam int unsigned Lg = $clog2(N_BARS);
  localparam logic [COORD_W-1:0] One     = COORD_W'(1);
  localparam logic [Lg-1:0]      BandOne = Lg'(1);
  localparam logic [Lg-1:0]      BandMax = Lg'(N_BARS - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StRun} state_e;

  state_e state_q, state_d;

  logic [1:0]         mode_q, mode_d;
  logic [23:0]        solid_q, solid_d;
  logic [COORD_W-1:0] horz_q, horz_d, vert_q, vert_d;
  logic [COORD_W-1:0] bar_w_q, bar_w_d, bar_h_q, bar_h_d;
  logic [COORD_W-1:0] px_x_q, px_x_d, px_y_q, px_y_d;
  logic [COORD_W-1:0] cc_q, cc_d, rc_q, rc_d;
  logic [Lg-1:0]      cb_q, cb_d, rb_q, rb_d;
  logic               write_q, write_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               fd_q, fd_d;

  logic [COORD_W-1:0] bar_w_raw, bar_h_raw;
  logic               accepted, last_px, win_open;
  logic [23:0]        colour;

  assign bar_w_raw = horz >> Lg;
  assign bar_h_raw = vert >> Lg;
  assign accepted  = write_q && !waitrequest;
  assign last_px   = (px_x_q == horz_q - One) && (px_y_q == vert_q - One);
  assign win_open  = (x < horz_q) && (y < vert_q);

  function automatic logic [23:0] pal(input logic [2:0] i);
    return {{8{i[2]}}, {8{i[1]}}, {8{i[0]}}};
  endfunction

  always_ff @(posedge clk_mm) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (enable && horz != '0 && vert != '0) state_d = StSetup;
      StSetup: state_d = StRun;
      StRun: begin
        // Restart only with a usable geometry, otherwise the window could never open.
        if (accepted && last_px) begin
          state_d = (enable && horz != '0 && vert != '0) ? StSetup : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mode_d  = mode_q;
    solid_d = solid_q;
    horz_d  = horz_q;
    vert_d  = vert_q;
    bar_w_d = bar_w_q;
    bar_h_d = bar_h_q;
    px_x_d  = px_x_q;
    px_y_d  = px_y_q;
    cc_d    = cc_q;
    rc_d    = rc_q;
    cb_d    = cb_q;
    rb_d    = rb_q;
    write_d = write_q;
    wdata_d = wdata_q;
    fd_d    = 1'b0;
    colour  = '0;

    unique case (state_q)
      StIdle: write_d = 1'b0;
      StSetup: begin
        mode_d  = mode;
        solid_d = solid_rgb;
        horz_d  = horz;
        vert_d  = vert;
        bar_w_d = (bar_w_raw == '0) ? One : bar_w_raw;
        bar_h_d = (bar_h_raw == '0) ? One : bar_h_raw;
        px_x_d  = '0;
        px_y_d  = '0;
        cc_d    = '0;
        rc_d    = '0;
        cb_d    = '0;
        rb_d    = '0;
        write_d = 1'b0;
      end
      StRun: begin
        if (accepted) begin
          if (last_px) begin
            fd_d    = 1'b1;
            write_d = 1'b0;
          end else begin
            if (px_x_q == horz_q - One) begin
              px_x_d = '0;
              px_y_d = px_y_q + One;
              cc_d   = '0;
              cb_d   = '0;
              if (rc_q == bar_h_q - One) begin
                rc_d = '0;
                if (rb_q != BandMax) rb_d = rb_q + BandOne;
              end else begin
                rc_d = rc_q + One;
              end
            end else begin
              px_x_d = px_x_q + One;
              if (cc_q == bar_w_q - One) begin
                cc_d = '0;
                if (cb_q != BandMax) cb_d = cb_q + BandOne;
              end else begin
                cc_d = cc_q + One;
              end
            end
            write_d = win_open;
          end
        end else if (!write_q) begin
          write_d = win_open;
        end
      end
      default: write_d = 1'b0;
    endcase

    unique case (mode_q)
      2'd0:    colour = pal(3'(rb_d));
      2'd1:    colour = pal(3'(cb_d));
      2'd2:    colour = (cb_d[0] ^ rb_d[0]) ? 24'hFFFFFF : 24'h000000;
      default: colour = solid_q;
    endcase

    // Data only moves when a fresh pixel is presented; a stalled write keeps its payload.
    if (state_q == StRun && write_d && !(write_q && waitrequest)) begin
      wdata_d = DATA_W'(colour);
    end
  end

  always_ff @(posedge clk_mm) begin
    if (reset) begin
      mode_q  <= '0;
      solid_q <= '0;
      horz_q  <= '0;
      vert_q  <= '0;
      bar_w_q <= '0;
      bar_h_q <= '0;
      px_x_q  <= '0;
      px_y_q  <= '0;
      cc_q    <= '0;
      rc_q    <= '0;
      cb_q    <= '0;
      rb_q    <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      fd_q    <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      solid_q <= solid_d;
      horz_q  <= horz_d;
      vert_q  <= vert_d;
      bar_w_q <= bar_w_d;
      bar_h_q <= bar_h_d;
      px_x_q  <= px_x_d;
      px_y_q  <= px_y_d;
      cc_q    <= cc_d;
      rc_q    <= rc_d;
      cb_q    <= cb_d;
      rb_q    <= rb_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      fd_q    <= fd_d;
    end
  end

  always_comb begin
    busy       = (state_q != StIdle);
    write      = write_q;
    writedata  = wdata_q;
    frame_done = fd_q;
    address    = ADDR_W'(WR_ADDR);
    byteenable = '1;
  end

endmodule

// File: tb/tb_avalon_pattern_gen.sv
// Scoreboard bench for avalon_pattern_gen: stimulus queues expected pixels and frame
// lengths, an independent monitor pops and compares on every accepted write.
module tb_avalon_pattern_gen;
  localparam int CW = 11;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk_mm = 1'b0;
  logic          reset, en1, en2, waitrequest, sel;
  logic [1:0]    mode;
  logic [23:0]   solid_rgb;
  logic [CW-1:0] x, y, horz, vert;

  logic          write1, write2, busy1, busy2, fd1, fd2;
  logic [AW-1:0] address1, address2;
  logic [DW-1:0] writedata1, writedata2;
  logic [3:0]    be1, be2;

  int total = 0;
  int bad = 0;
  int fd_cnt = 0;
  int px_cnt = 0;
  logic [23:0] exp_q[$];
  int          flen_q[$];

  logic          m_w, m_f, m_f_prev;
  logic [DW-1:0] m_d;
  logic [AW-1:0] m_a;
  logic [3:0]    m_be;
  logic [23:0]   m_exp;

  always #5 clk_mm = ~clk_mm;

  avalon_pattern_gen #(.N_BARS(8), .COORD_W(CW), .ADDR_W(AW), .DATA_W(DW), .WR_ADDR(0)) dut (
    .clk_mm(clk_mm), .reset(reset), .enable(en1), .mode(mode), .solid_rgb(solid_rgb),
    .x(x), .y(y), .horz(horz), .vert(vert), .write(write1), .address(address1),
    .writedata(writedata1), .byteenable(be1), .waitrequest(waitrequest), .busy(busy1),
    .frame_done(fd1)
  );

  avalon_pattern_gen #(.N_BARS(2), .COORD_W(CW), .ADDR_W(AW), .DATA_W(DW), .WR_ADDR(0)) dut2 (
    .clk_mm(clk_mm), .reset(reset), .enable(en2), .mode(mode), .solid_rgb(solid_rgb),
    .x(x), .y(y), .horz(horz), .vert(vert), .write(write2), .address(address2),
    .writedata(writedata2), .byteenable(be2), .waitrequest(waitrequest), .busy(busy2),
    .frame_done(fd2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [23:0] model_px(input int m, input logic [23:0] s, input int h,
                                           input int v, input int nb, input int px,
                                           input int py);
    int lg, bw, bh, cb, rb, idx;
    lg = $clog2(nb);
    bw = h >> lg;
    bh = v >> lg;
    if (bw == 0) bw = 1;
    if (bh == 0) bh = 1;
    cb = px / bw;
    rb = py / bh;
    if (cb > nb - 1) cb = nb - 1;
    if (rb > nb - 1) rb = nb - 1;
    case (m)
      0: idx = rb;
      1: idx = cb;
      2: return ((cb ^ rb) & 1) != 0 ? 24'hFFFFFF : 24'h000000;
      default: return s;
    endcase
    return {((idx & 4) != 0) ? 8'hFF : 8'h00, ((idx & 2) != 0) ? 8'hFF : 8'h00,
            ((idx & 1) != 0) ? 8'hFF : 8'h00};
  endfunction

  task automatic push_frame(input int m, input logic [23:0] s, input int h, input int v,
                            input int nb);
    for (int py = 0; py < v; py++)
      for (int px = 0; px < h; px++) exp_q.push_back(model_px(m, s, h, v, nb, px, py));
    flen_q.push_back(h * v);
  endtask

  task automatic step();
    @(posedge clk_mm);
    #1;
  endtask

  task automatic wait_busy(input logic want);
    int n = 0;
    @(negedge clk_mm);
    while (((sel ? busy2 : busy1) !== want) && n < 200) begin
      @(negedge clk_mm);
      n++;
    end
    check("busy_wait", 32'(sel ? busy2 : busy1), 32'(want));
  endtask

  task automatic wait_fd(input int target);
    int n = 0;
    while (fd_cnt < target && n < 5000) begin
      @(negedge clk_mm);
      n++;
    end
    check("frame_count", fd_cnt, target);
  endtask

  task automatic run_single(input int m, input logic [23:0] s, input int h, input int v,
                            input int nb);
    int tgt;
    mode = 2'(m);
    solid_rgb = s;
    horz = CW'(h);
    vert = CW'(v);
    push_frame(m, s, h, v, nb);
    tgt = fd_cnt + 1;
    if (sel) en2 = 1'b1;
    else     en1 = 1'b1;
    wait_busy(1'b1);
    step();
    en1 = 1'b0;
    en2 = 1'b0;
    wait_fd(tgt);
    wait_busy(1'b0);
    step();
  endtask

  // Monitor: every accepted write pops one expected pixel; every frame_done pops a frame length.
  always @(negedge clk_mm) begin
    m_w  = sel ? write2 : write1;
    m_d  = sel ? writedata2 : writedata1;
    m_f  = sel ? fd2 : fd1;
    m_a  = sel ? address2 : address1;
    m_be = sel ? be2 : be1;
    if (!reset) begin
      if (m_w && !waitrequest) begin
        px_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write actual=%h required=no_write", m_d);
        end else begin
          m_exp = exp_q.pop_front();
          check("pixel", m_d, {8'h00, m_exp});
          check("addr_be", {18'd0, m_a, m_be}, {18'd0, 10'd0, 4'hF});
        end
      end
      if (m_f) begin
        fd_cnt++;
        check("fd_one_cycle", 32'(m_f_prev), 32'd0);
        if (flen_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_frame_done actual=%0d required=none", px_cnt);
        end else begin
          check("frame_len", px_cnt, flen_q.pop_front());
        end
        px_cnt = 0;
      end
    end
    m_f_prev = m_f;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n, tgt;
    reset = 1'b1; en1 = 1'b0; en2 = 1'b0; waitrequest = 1'b0; sel = 1'b0;
    mode = 2'd0; solid_rgb = '0; x = '0; y = '0; horz = '0; vert = '0;
    m_f_prev = 1'b0;
    repeat (3) step();
    @(negedge clk_mm);
    check("rst_write", 32'(write1), 0);
    check("rst_busy", 32'(busy1), 0);
    check("rst_fd", 32'(fd1), 0);
    check("rst_wdata", writedata1, 0);
    check("rst_write2", 32'(write2), 0);
    step();
    reset = 1'b0;
    step();

    run_single(0, 24'h0, 16, 8, 8);   // horizontal bars
    run_single(1, 24'h0, 20, 4, 8);   // vertical bars, clamped remainder
    sel = 1'b1;
    run_single(2, 24'h0, 4, 4, 2);    // checkerboard on the 2-band instance
    sel = 1'b0;

    // Stall on pixel 3 while the window closes
    mode = 2'd1; horz = 8; vert = 1; x = 0; y = 0;
    push_frame(1, 24'h0, 8, 1, 8);
    tgt = fd_cnt + 1;
    en1 = 1'b1;
    wait_busy(1'b1);
    step();
    en1 = 1'b0;
    n = 0;
    do begin
      @(negedge clk_mm);
      n++;
    end while (!(write1 && writedata1 == 32'h0000FF00) && n < 100);
    check("pix2_seen", writedata1, 32'h0000FF00);
    step();
    waitrequest = 1'b1;
    x = 8;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_mm);
      check("stall_write", 32'(write1), 1);
      check("stall_data", writedata1, 32'h0000FFFF);
      step();
    end
    waitrequest = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_mm);
      check("closed_no_write", 32'(write1), 0);
      step();
    end
    x = 0;
    wait_fd(tgt);
    wait_busy(1'b0);
    step();

    // Mode change mid-frame only affects the next frame
    mode = 2'd0; solid_rgb = 24'h0; horz = 4; vert = 2;
    push_frame(0, 24'h0, 4, 2, 8);
    push_frame(3, 24'h123456, 4, 2, 8);
    tgt = fd_cnt + 2;
    en1 = 1'b1;
    wait_busy(1'b1);
    repeat (3) step();
    mode = 2'd3;
    solid_rgb = 24'h123456;
    wait_fd(tgt - 1);
    step();
    en1 = 1'b0;
    wait_fd(tgt);
    wait_busy(1'b0);
    step();

    // Reset while a write is stalled
    mode = 2'd0; horz = 4; vert = 2; waitrequest = 1'b1;
    en1 = 1'b1;
    n = 0;
    do begin
      @(negedge clk_mm);
      n++;
    end while (!write1 && n < 100);
    check("pre_rst_write", 32'(write1), 1);
    step();
    reset = 1'b1;
    step();
    @(negedge clk_mm);
    check("rst_stall_write", 32'(write1), 0);
    check("rst_stall_busy", 32'(busy1), 0);
    check("rst_stall_fd", 32'(fd1), 0);
    push_frame(0, 24'h0, 4, 2, 8);
    tgt = fd_cnt + 1;
    step();
    reset = 1'b0;
    waitrequest = 1'b0;
    wait_busy(1'b1);
    step();
    en1 = 1'b0;
    wait_fd(tgt);
    wait_busy(1'b0);
    repeat (3) step();
    check("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/avalon_pattern_gen.md
Name: avalon_pattern_gen

Overview:
Parametrised test-pattern source that streams RGB pixels into the HDMI core's Avalon-MM slave write port, one pixel per accepted write. It supports horizontal bars, vertical bars, a checkerboard and a solid colour, all selectable at run time. Pattern geometry comes from the HDMI core's horz/vert outputs. Writes are paced by the core's active window (x/y) and waitrequest. It replaces the fixed 8-bar horizontal generator in hardware test tops.

Parameters:
N_BARS, 8, number of colour bands; power of two, 2..256
COORD_W, 11, width of x/y/horz/vert
ADDR_W, 10, Avalon address width
DATA_W, 32, Avalon write data width; must be >= 24
WR_ADDR, 0, constant address driven on every write (streaming port)

Ports:
clk_mm  in  1  Avalon clock from the HDMI core; all logic on its rising edge
reset  in  1  synchronous, active-high
enable  in  1  run request
mode  in  2  0=horizontal bars, 1=vertical bars, 2=checkerboard, 3=solid
solid_rgb  in  24  colour for mode 3 ({B,G,R})
x, y  in  COORD_W  current scan position from the HDMI core
horz, vert  in  COORD_W  active width/height
write  out  1  Avalon write
address  out  ADDR_W  always WR_ADDR
writedata  out  DATA_W  {zeros, B[23:16], G[15:8], R[7:0]}
byteenable  out  DATA_W/8  all ones
waitrequest  in  1  slave stall
busy  out  1  high outside IDLE
frame_done  out  1  one-cycle pulse when the last pixel of a frame is accepted

Behaviour:
- Clock is clk_mm; reset is synchronous, active-high. Reset values: write=0, writedata=0, busy=0, frame_done=0, state=IDLE, all counters=0. Reset wins over every other event, including a pending stalled write: write drops on the next edge.
- An accepted write is write && !waitrequest.
- IDLE: if enable && horz!=0 && vert!=0, go to SETUP. Otherwise remain in IDLE.
- SETUP (1 cycle): latch mode, solid_rgb, horz and vert into frame registers. Compute bar_w = horz>>log2(N_BARS) and bar_h = vert>>log2(N_BARS); either result is forced to 1 if it computes to 0. Clear px_x, px_y, band counters. Go to RUN.
- RUN:
  - Write issue: when no write is pending and x<horz && y<vert, drive write=1 with the current pixel's colour.
  - While waitrequest=1, write, address and writedata hold stable. This holds even if the window closes or enable drops.
  - After an accepted write: if the window is still open, the next pixel is presented in the following cycle with no bubble; otherwise write=0.
- Pixel position after each accepted write:
  - px_x increments. At px_x=horz_l-1 it wraps to 0 and px_y increments.
  - Column band counter cb: advances every bar_w columns and saturates at N_BARS-1, so remainder columns take the last colour. Resets per line.
  - Row band counter rb: same rule over rows with bar_h.
- Colour index: mode0=rb, mode1=cb, mode2=(cb^rb)&1 selecting black/white, mode3=solid_rgb.
- Palette for index i: R=i[0]?FF:00, G=i[1]?FF:00, B=i[2]?FF:00. Indices >=8 use i mod 8.
- Frame end: on the accepted write of pixel (horz_l-1, vert_l-1), pulse frame_done for one cycle.
  - If enable=1, go to SETUP. New mode/horz/vert/solid_rgb take effect only there; mid-frame input changes are ignored.
  - If enable=0, go to IDLE.
- enable=0 mid-frame does not abort; the frame completes.
- No division logic; all counter arithmetic is COORD_W bits wide.

Test Plan:
- horz=16, vert=8, mode0, N_BARS=8, waitrequest=0, window always open -> 128 writes, row r data=palette(r) (row1=0x0000FF, row4=0xFF0000, row7=0xFFFFFF), frame_done pulses once on write 128.
- horz=20, vert=4, mode1 -> bar_w=2; cols 0-1=0x000000, 2-3=0x0000FF, cols 14-19=0xFFFFFF (clamped remainder).
- horz=4, vert=4, N_BARS=2, mode2 -> bar_w=bar_h=2; row0 data 000000,000000,FFFFFF,FFFFFF; row2 inverted.
- waitrequest held high 5 cycles on pixel 3, window closes during the stall -> write/writedata unchanged for all 5 cycles; pixel 4 is issued only when the window reopens.
- mode changed 0->3 (solid_rgb=0x123456) mid-frame -> rest of frame unchanged; next frame is all 0x123456 after one SETUP cycle.
- reset asserted while write=1 and waitrequest=1 -> next edge write=0, busy=0, frame_done=0; after release with enable=1, first pixel data=palette(0).
